// File: rtl/bitrev_reorder_ctrl_pkg.sv
// Shared FFT definitions: frame-size helpers, bit-reversal and reorder read FSM states.
package fft_pkg;

    localparam int unsigned N_DEFAULT = 3;
    localparam int unsigned D_DEFAULT = 1 << N_DEFAULT;

    typedef enum logic {
        IDLE,
        DRAIN
    } rd_state_t;

    // Reverses the low n bits of v; bits at and above n are returned as zero.
    function automatic logic [15:0] rev_bits(input logic [15:0] v, input int unsigned n);
        logic [15:0] r;
        r = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i < n) r[i] = v[n - 1 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bitrev_reorder_ctrl_addr_cnt.sv
// N-bit wrapping address counter with terminal-count flag and bit-reversed view.
module bitrev_addr_cnt
    import fft_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [N-1:0] cnt,
    output logic         tc,
    output logic [N-1:0] rev
);

    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end

    assign tc  = (cnt == '1);
    assign rev = N'(rev_bits(16'(cnt), N));

endmodule

// File: rtl/bitrev_reorder_ctrl.sv
// Ping-pong reorder buffer address/handshake controller: bit-reversed writes, natural-order drain.
// Optional natural-order write mode for debug: BITREV_REORDER_BYPASS_EN.
module bitrev_reorder_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         wr_en,
    output logic         wr_bank,
    output logic [N-1:0] wr_addr,
    output logic         rd_en,
    output logic         rd_bank,
    output logic [N-1:0] rd_addr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last
`ifdef BITREV_REORDER_BYPASS_EN
    ,
    input  logic         bypass
`endif
);

    rd_state_t    state, state_nxt;
    logic [1:0]   full;
    logic [N-1:0] wcnt, wrev;
    logic         wtc, rtc, rd_active;

    bitrev_addr_cnt #(.N(N)) u_wcnt (
        .clk (clk),
        .rst (rst),
        .en  (wr_en),
        .cnt (wcnt),
        .tc  (wtc),
        .rev (wrev)
    );

    bitrev_addr_cnt #(.N(N)) u_rcnt (
        .clk (clk),
        .rst (rst),
        .en  (rd_en),
        .cnt (rd_addr),
        .tc  (rtc),
        .rev ()
    );

    assign in_ready = !full[wr_bank];
    assign wr_en    = in_valid & in_ready;

`ifdef BITREV_REORDER_BYPASS_EN
    logic bypass_mode;

    always_ff @(posedge clk) begin
        if (rst) bypass_mode <= 1'b0;
        else if (wcnt == '0 && rd_addr == '0 && full == 2'b00) bypass_mode <= bypass;
    end

    assign wr_addr = bypass_mode ? wcnt : wrev;
`else
    assign wr_addr = wrev;
`endif

    // A full bank is drained from the cycle its flag is visible, so IDLE never costs a cycle.
    always_comb begin
        rd_active = (state == DRAIN) | full[rd_bank];
        rd_en     = rd_active & (!out_valid | out_ready);
        state_nxt = state;
        if (rd_active) begin
            state_nxt = DRAIN;
            if (rd_en && rtc) begin
                state_nxt = (full[~rd_bank] | (wr_en & wtc & (wr_bank != rd_bank))) ? DRAIN : IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end

    // Set and clear always address opposite banks, so both updates may land in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            full      <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (wr_en && wtc) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end
            if (rd_en && rtc) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
            if (!out_valid || out_ready) begin
                out_valid <= rd_en;
                out_last  <= rd_en & rtc;
            end
        end
    end

endmodule

// File: tb/tb_bitrev_reorder_ctrl.sv
// Scoreboard bench for bitrev_reorder_ctrl with a behavioural dual-bank RAM; N=3.
module tb_bitrev_reorder_ctrl;

    localparam int unsigned N = 3;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, wr_en, wr_bank, rd_en, rd_bank;
    logic         out_valid, out_ready, out_last;
    logic [N-1:0] wr_addr, rd_addr;
`ifdef BITREV_REORDER_BYPASS_EN
    logic         bypass;
`endif

    always #5 clk = ~clk;

    bitrev_reorder_ctrl #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_bank   (wr_bank),
        .wr_addr   (wr_addr),
        .rd_en     (rd_en),
        .rd_bank   (rd_bank),
        .rd_addr   (rd_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
`ifdef BITREV_REORDER_BYPASS_EN
        ,
        .bypass    (bypass)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int mem [2][8];
    int rdata = 0;
    int sid_w = 0;
    int wq[$];
    int rq[$];
    int oq[$];
    int brv[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int last_wr_cyc = 0;
    int ov_rise_cyc = -1;
    int ir_low = 0;
    int base = 0;
    logic prev_ov = 1'b0;
    logic prev_stall = 1'b0;
    int prev_data = 0;
    logic prev_last = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: 1-cycle read latency, output held while rd_en is low.
    always @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= sid_w;
            sid_w <= sid_w + 1;
        end
        if (rd_en) rdata <= mem[rd_bank][rd_addr];
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_data", rdata, prev_data);
                chk("hold_last", int'(out_last), int'(prev_last));
            end
            if (wr_en) begin
                last_wr_cyc = cyc;
                if (wq.size() == 0) chk("unexpected_write", int'(wr_bank) * 8 + int'(wr_addr), -1);
                else chk("wr_bank_addr", int'(wr_bank) * 8 + int'(wr_addr), wq.pop_front());
            end
            if (rd_en) begin
                if (rq.size() == 0) chk("unexpected_read", int'(rd_bank) * 8 + int'(rd_addr), -1);
                else chk("rd_bank_addr", int'(rd_bank) * 8 + int'(rd_addr), rq.pop_front());
            end
            if (out_valid && out_ready) begin
                if (oq.size() == 0) chk("unexpected_output", int'(out_last) * 1000 + rdata, -1);
                else chk("out_last_data", int'(out_last) * 1000 + rdata, oq.pop_front());
            end
            if (out_valid && !prev_ov && ov_rise_cyc < 0) ov_rise_cyc = cyc;
            if (in_valid && !in_ready) ir_low++;
        end
        prev_ov    = out_valid;
        prev_stall = out_valid && !out_ready && !rst;
        prev_data  = rdata;
        prev_last  = out_last;
    end

    task automatic push_frame(input int bank, input int fbase, input int nat);
        for (int a = 0; a < 8; a++) begin
            wq.push_back(bank * 8 + ((nat != 0) ? a : brv[a]));
            rq.push_back(bank * 8 + a);
            oq.push_back(((a == 7) ? 1000 : 0) + fbase + ((nat != 0) ? a : brv[a]));
        end
    endtask

    task automatic send(input int n);
        int k;
        int guard;
        k = 0;
        guard = 0;
        in_valid = 1'b1;
        while (k < n) begin
            @(negedge clk);
            if (wr_en) k++;
            @(posedge clk);
            #1;
            guard++;
            if (guard > 200) begin
                chk("send_timeout", k, n);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain_wait();
        int g;
        g = 0;
        while ((wq.size() + rq.size() + oq.size()) != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("queues_drained", wq.size() + rq.size() + oq.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_bank", int'(wr_bank), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_rd_bank", int'(rd_bank), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bool_found_init();
    end

    task automatic bool_found_init();
    endtask

    initial begin
        int found;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
`ifdef BITREV_REORDER_BYPASS_EN
        bypass = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Single frame: bit-reversed writes, natural drain, 2-cycle first-output latency.
        push_frame(0, base, 0);
        send(8);
        base += 8;
        drain_wait();
        chk("first_out_latency", ov_rise_cyc - last_wr_cyc, 2);

        // Four frames streamed back to back.
        do_reset();
        ir_low = 0;
        for (int f = 0; f < 4; f++) push_frame(f % 2, base + 8 * f, 0);
        send(32);
        base += 32;
        drain_wait();
        chk("swap_stalls_le3", int'(ir_low <= 3), 1);

        // Consumer stalled while two frames arrive.
        out_ready = 1'b0;
        push_frame(0, base, 0);
        push_frame(1, base + 8, 0);
        send(16);
        base += 16;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("both_full_in_ready", int'(in_ready), 0);
        chk("stall_out_valid", int'(out_valid), 1);
        chk("stall_rd_en", int'(rd_en), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("blocked_wr_en", int'(wr_en), 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            @(negedge clk);
            if (rd_en && rd_bank == 1'b0 && rd_addr == 3'd7) found = 1;
        end
        chk("bank0_free_seen", found, 1);
        chk("in_ready_at_free", int'(in_ready), 0);
        @(negedge clk);
        chk("in_ready_after_free", int'(in_ready), 1);
        drain_wait();

        // Reset part-way through a frame discards it.
        for (int j = 0; j < 5; j++) wq.push_back(brv[j]);
        send(5);
        base += 5;
        do_reset();
        push_frame(0, base, 0);
        send(8);
        base += 8;
        drain_wait();

        // Consumer toggling ready during the drain.
        fork
            send(8);
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1;
                    out_ready = ~out_ready;
                end
            end
        join_none
        push_frame(1, base, 0);
        wait fork;
        base += 8;
        out_ready = 1'b1;
        drain_wait();

`ifdef BITREV_REORDER_BYPASS_EN
        // Natural-order pass-through latched at the idle point.
        bypass = 1'b1;
        @(posedge clk);
        #1;
        push_frame(0, base, 1);
        send(8);
        base += 8;
        drain_wait();
        bypass = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
